// File: rtl/segre_pkg.sv
// Shared core definitions: memory geometry, access sizes and main-memory arbiter constants.
package segre_pkg;

    localparam int ADDR_SIZE             = 32;
    localparam int CACHE_LINE_SIZE_BYTES = 16;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } memop_data_type_e;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Requesters sharing the main-memory port, in arbiter port order.
    localparam int MEM_ARB_PORTS = 3;
    localparam int MEM_PORT_IF   = 0;
    localparam int MEM_PORT_MEM  = 1;
    localparam int MEM_PORT_SB   = 2;

endpackage

// File: rtl/segre_rr_picker.sv
// Combinational rotating picker: first set request at or after ptr_i (wrapping modulo N),
// returned both one-hot and as an index. Shared by the core's arbiters.
module segre_rr_picker #(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             valid_o
);

    localparam int SUM_W = PTR_W + 1;

    logic [SUM_W-1:0] pos;

    // NOTE: every output gets a default before the scan so no path leaves one unassigned (no latch).
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        pos     = '0;
        for (int i = 0; i < N; i++) begin
            pos = SUM_W'(ptr_i) + SUM_W'(i);
            if (pos >= SUM_W'(N)) pos = pos - SUM_W'(N);
            if (!valid_o && req_i[pos[PTR_W-1:0]]) begin
                valid_o                = 1'b1;
                idx_o                  = pos[PTR_W-1:0];
                gnt_o[pos[PTR_W-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/segre_mem_arbiter.sv
// N-port main-memory arbiter with registered launch, bus lock and lock idle timeout.
// Define SEGRE_MEM_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module segre_mem_arbiter
    import segre_pkg::*;
#(
    parameter int N_PORTS      = 2,
    parameter int ADDR_W       = ADDR_SIZE,
    parameter int LINE_BYTES   = CACHE_LINE_SIZE_BYTES,
    parameter int LOCK_TIMEOUT = 15
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [N_PORTS-1:0]                   req_rd_i,
    input  logic [N_PORTS-1:0]                   req_wr_i,
    input  logic [N_PORTS-1:0]                   req_lock_i,
    input  logic [N_PORTS-1:0][ADDR_W-1:0]       req_addr_i,
    input  memop_data_type_e [N_PORTS-1:0]       req_data_type_i,
    input  logic [N_PORTS-1:0][LINE_BYTES*8-1:0] req_wr_data_i,
    output logic [N_PORTS-1:0]                   req_ready_o,
    output logic [LINE_BYTES*8-1:0]              req_rd_data_o,
    output logic [N_PORTS-1:0]                   grant_o,
    output logic [ADDR_W-1:0]                    mem_addr_o,
    output logic                                 mem_rd_o,
    output logic                                 mem_wr_o,
    output memop_data_type_e                     mem_data_type_o,
    output logic [LINE_BYTES*8-1:0]              mem_wr_data_o,
    input  logic [LINE_BYTES*8-1:0]              mem_rd_data_i,
    input  logic                                 mem_ready_i
);

    localparam int PTR_W = $clog2(N_PORTS);
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

    arb_state_e         state_q;
    logic [PTR_W-1:0]   owner_q;
    logic               lock_q;
    logic [CNT_W-1:0]   lock_cnt_q;

    logic [N_PORTS-1:0] req_any;
    logic [N_PORTS-1:0] pick_req;
    logic [N_PORTS-1:0] pick_gnt;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W-1:0]   pick_ptr;
    logic               pick_valid;
    logic               done;

    assign req_any  = req_rd_i | req_wr_i;
    // While locked, grant_o still names the owner, so masking with it restricts the pick to the owner.
    assign pick_req = lock_q ? (req_any & grant_o) : req_any;
    assign done     = (state_q == ARB_BUSY) && mem_ready_i;

    assign req_ready_o   = done ? grant_o : '0;
    assign req_rd_data_o = mem_rd_data_i;

`ifdef SEGRE_MEM_ARB_FIXED_PRIO_EN
    assign pick_ptr = '0;
`else
    logic [PTR_W-1:0] rr_ptr_q;
    logic [PTR_W-1:0] owner_next;

    // Explicit wrap keeps the pointer in range for non-power-of-two port counts.
    assign owner_next = (owner_q == PTR_W'(N_PORTS - 1)) ? '0 : owner_q + PTR_W'(1);
    assign pick_ptr   = rr_ptr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)     rr_ptr_q <= '0;
        else if (done) rr_ptr_q <= owner_next;
    end
`endif

    segre_rr_picker #(
        .N     (N_PORTS),
        .PTR_W (PTR_W)
    ) u_picker (
        .req_i   (pick_req),
        .ptr_i   (pick_ptr),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= ARB_IDLE;
            grant_o         <= '0;
            owner_q         <= '0;
            lock_q          <= 1'b0;
            lock_cnt_q      <= '0;
            mem_addr_o      <= '0;
            mem_rd_o        <= 1'b0;
            mem_wr_o        <= 1'b0;
            mem_data_type_o <= WORD;
            mem_wr_data_o   <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        state_q         <= ARB_BUSY;
                        grant_o         <= pick_gnt;
                        owner_q         <= pick_idx;
                        lock_cnt_q      <= '0;
                        mem_addr_o      <= req_addr_i[pick_idx];
                        mem_rd_o        <= req_rd_i[pick_idx];
                        mem_wr_o        <= req_wr_i[pick_idx];
                        mem_data_type_o <= req_data_type_i[pick_idx];
                        mem_wr_data_o   <= req_wr_data_i[pick_idx];
                    end else if (lock_q) begin
                        lock_cnt_q <= lock_cnt_q + CNT_W'(1);
                        if (lock_cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                            lock_q  <= 1'b0;
                            grant_o <= '0;
                        end
                    end
                end
                ARB_BUSY: begin
                    if (mem_ready_i) begin
                        state_q  <= ARB_IDLE;
                        mem_rd_o <= 1'b0;
                        mem_wr_o <= 1'b0;
                        lock_q   <= req_lock_i[owner_q];
                        if (!req_lock_i[owner_q]) grant_o <= '0;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

endmodule
